// File: rtl/operator_waveform.sv
// operator_waveform: per-operator phase accumulators feeding a log-sine /
// exponential waveform synthesizer; 4-stage pipeline from tick to signed sample.
module operator_waveform #(
   parameter int unsigned NUM_OPS = 18,
   parameter int unsigned SILENCE = 511
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_clk_en,
   input  logic [4:0]         op_num,
   input  logic [9:0]         fnum,
   input  logic [2:0]         block,
   input  logic [3:0]         mult,
   input  logic [1:0]         ws,
   input  logic [8:0]         env,
   input  logic [9:0]         modulation,
   input  logic               key_on_pulse,
   output logic signed [12:0] out,
   output logic [4:0]         out_op_num,
   output logic               out_valid
);

   localparam real PI = 3.14159265358979323846;
   localparam logic [8:0] SILENCE_ENV = 9'(SILENCE);

   // ROM images are built at elaboration; a runtime part-select becomes the ROM.
   function automatic logic [256*12-1:0] gen_logsin();
      logic [256*12-1:0] rom;
      logic [11:0]       base;
      real               s;
      rom = '0;
      for (int unsigned a = 0; a < 256; a++) begin
         base = 12'(a * 12);
         s = $sin((real'(a) + 0.5) * PI / 512.0);
         rom[base +: 12] = 12'($rtoi(-$ln(s) / $ln(2.0) * 256.0 + 0.5));
      end
      return rom;
   endfunction

   function automatic logic [256*10-1:0] gen_exp();
      logic [256*10-1:0] rom;
      logic [11:0]       base;
      rom = '0;
      for (int unsigned a = 0; a < 256; a++) begin
         base = 12'(a * 10);
         rom[base +: 10] = 10'($rtoi(($pow(2.0, real'(a) / 256.0) - 1.0) * 1024.0 + 0.5));
      end
      return rom;
   endfunction

   localparam logic [256*12-1:0] LOGSIN_ROM = gen_logsin();
   localparam logic [256*10-1:0] EXP_ROM    = gen_exp();

   logic [19:0] phase_q [NUM_OPS];
   logic [19:0] phase_d [NUM_OPS];

   logic        vld0_q, vld0_d, neg0_q, neg0_d, mute0_q, mute0_d;
   logic [7:0]  addr0_q, addr0_d;
   logic [8:0]  env0_q, env0_d;
   logic [4:0]  op0_q, op0_d;

   logic        vld1_q, vld1_d, neg1_q, neg1_d, mute1_q, mute1_d;
   logic [11:0] logsin1_q, logsin1_d;
   logic [8:0]  env1_q, env1_d;
   logic [4:0]  op1_q, op1_d;

   logic        vld2_q, vld2_d, neg2_q, neg2_d, mute2_q, mute2_d;
   logic [9:0]  exp2_q, exp2_d;
   logic [4:0]  shift2_q, shift2_d;
   logic [4:0]  op2_q, op2_d;

   logic signed [12:0] out_q, out_d;
   logic [4:0]         out_op_q, out_op_d;
   logic               out_valid_q, out_valid_d;

   logic [4:0]  mult2;
   logic [16:0] shifted;
   logic [19:0] inc;
   logic [19:0] cur_phase;
   logic [9:0]  idx;
   logic [12:0] att;
   logic [11:0] base_mag;
   logic [11:0] mag;

   always_comb begin
      mult2 = '0;
      case (mult)
         4'd0:  mult2 = 5'd1;
         4'd1:  mult2 = 5'd2;
         4'd2:  mult2 = 5'd4;
         4'd3:  mult2 = 5'd6;
         4'd4:  mult2 = 5'd8;
         4'd5:  mult2 = 5'd10;
         4'd6:  mult2 = 5'd12;
         4'd7:  mult2 = 5'd14;
         4'd8:  mult2 = 5'd16;
         4'd9:  mult2 = 5'd18;
         4'd10: mult2 = 5'd20;
         4'd11: mult2 = 5'd20;
         4'd12: mult2 = 5'd24;
         4'd13: mult2 = 5'd24;
         4'd14: mult2 = 5'd30;
         4'd15: mult2 = 5'd30;
         default: mult2 = '0;
      endcase
      shifted = {7'd0, fnum} << block;
      inc = 20'(({5'd0, shifted} * {17'd0, mult2}) >> 1);

      cur_phase = '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
         if (op_num == 5'(i)) cur_phase = phase_q[i];
      end

      // Key-on outranks the advance; the sample still sees the pre-update phase.
      phase_d = phase_q;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
         if (op_num == 5'(i)) begin
            if (key_on_pulse)       phase_d[i] = '0;
            else if (sample_clk_en) phase_d[i] = phase_q[i] + inc;
         end
      end

      idx     = cur_phase[19:10] + modulation;
      vld0_d  = sample_clk_en;
      addr0_d = idx[8] ? ~idx[7:0] : idx[7:0];
      neg0_d  = (ws == 2'd0) && idx[9];
      mute0_d = (env >= SILENCE_ENV) || ((ws == 2'd1) && idx[9]) || ((ws == 2'd3) && idx[8]);
      env0_d  = env;
      op0_d   = op_num;

      vld1_d    = vld0_q;
      logsin1_d = LOGSIN_ROM[{4'd0, addr0_q} * 12'd12 +: 12];
      neg1_d    = neg0_q;
      mute1_d   = mute0_q;
      env1_d    = env0_q;
      op1_d     = op0_q;

      att      = {1'b0, logsin1_q} + {1'b0, env1_q, 3'b000};
      vld2_d   = vld1_q;
      exp2_d   = EXP_ROM[{4'd0, ~att[7:0]} * 12'd10 +: 10];
      shift2_d = att[12:8];
      neg2_d   = neg1_q;
      mute2_d  = mute1_q;
      op2_d    = op1_q;

      base_mag    = {1'b1, exp2_q, 1'b0};
      mag         = (shift2_q >= 5'd12) ? '0 : (base_mag >> shift2_q);
      out_valid_d = vld2_q;
      out_d       = out_q;
      out_op_d    = out_op_q;
      if (vld2_q) begin
         out_op_d = op2_q;
         if (mute2_q)     out_d = '0;
         else if (neg2_q) out_d = -$signed({1'b0, mag});
         else             out_d = $signed({1'b0, mag});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q     <= '{default: '0};
         vld0_q      <= 1'b0;
         neg0_q      <= 1'b0;
         mute0_q     <= 1'b0;
         addr0_q     <= '0;
         env0_q      <= '0;
         op0_q       <= '0;
         vld1_q      <= 1'b0;
         neg1_q      <= 1'b0;
         mute1_q     <= 1'b0;
         logsin1_q   <= '0;
         env1_q      <= '0;
         op1_q       <= '0;
         vld2_q      <= 1'b0;
         neg2_q      <= 1'b0;
         mute2_q     <= 1'b0;
         exp2_q      <= '0;
         shift2_q    <= '0;
         op2_q       <= '0;
         out_q       <= '0;
         out_op_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         vld0_q      <= vld0_d;
         neg0_q      <= neg0_d;
         mute0_q     <= mute0_d;
         addr0_q     <= addr0_d;
         env0_q      <= env0_d;
         op0_q       <= op0_d;
         vld1_q      <= vld1_d;
         neg1_q      <= neg1_d;
         mute1_q     <= mute1_d;
         logsin1_q   <= logsin1_d;
         env1_q      <= env1_d;
         op1_q       <= op1_d;
         vld2_q      <= vld2_d;
         neg2_q      <= neg2_d;
         mute2_q     <= mute2_d;
         exp2_q      <= exp2_d;
         shift2_q    <= shift2_d;
         op2_q       <= op2_d;
         out_q       <= out_d;
         out_op_q    <= out_op_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out        = out_q;
   assign out_op_num = out_op_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_operator_waveform.sv
// Directed self-checking bench for operator_waveform: reset, phase advance,
// waveform sign/mute, envelope scaling, key-on, modulation wrap, interleaving.
module tb_operator_waveform;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               sample_clk_en;
   logic [4:0]         op_num;
   logic [9:0]         fnum;
   logic [2:0]         block;
   logic [3:0]         mult;
   logic [1:0]         ws;
   logic [8:0]         env;
   logic [9:0]         modulation;
   logic               key_on_pulse;
   logic signed [12:0] out;
   logic [4:0]         out_op_num;
   logic               out_valid;

   int n_checks = 0;
   int n_errors = 0;
   int ph [18];
   int mt [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

   operator_waveform #(.NUM_OPS(18), .SILENCE(511)) dut (
      .clk(clk), .rst(rst), .sample_clk_en(sample_clk_en), .op_num(op_num),
      .fnum(fnum), .block(block), .mult(mult), .ws(ws), .env(env),
      .modulation(modulation), .key_on_pulse(key_on_pulse),
      .out(out), .out_op_num(out_op_num), .out_valid(out_valid)
   );

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Expected operator sample straight from the lookup formulas.
   function automatic int ref_out(input int phase, input int md, input int w, input int e);
      int idx, a, ls, att, ex, sh, mag;
      bit neg, mute;
      idx  = ((phase >> 10) + md) & 1023;
      a    = ((idx & 256) != 0) ? 255 - (idx & 255) : (idx & 255);
      ls   = int'(-$ln($sin((a + 0.5) * 3.14159265358979 / 512.0)) / $ln(2.0) * 256.0);
      att  = ls + e * 8;
      ex   = int'(($pow(2.0, (255 - (att & 255)) / 256.0) - 1.0) * 1024.0);
      sh   = att >> 8;
      mag  = (sh >= 12) ? 0 : (((ex + 1024) * 2) >> sh);
      neg  = (w == 0) && ((idx & 512) != 0);
      mute = (e >= 511) || ((w == 1) && ((idx & 512) != 0)) || ((w == 3) && ((idx & 256) != 0));
      return mute ? 0 : (neg ? -mag : mag);
   endfunction

   function automatic void model_update(input int op, input int f, input int b, input int m,
                                        input bit tk, input bit kon);
      if (kon)     ph[op] = 0;
      else if (tk) ph[op] = (ph[op] + ((((f << b) * mt[m]) >> 1) & 20'hFFFFF)) & 20'hFFFFF;
   endfunction

   task automatic drive(input int op, input int f, input int b, input int m, input int w,
                        input int e, input int md, input bit tk, input bit kon);
      op_num = 5'(op); fnum = 10'(f); block = 3'(b); mult = 4'(m);
      ws = 2'(w); env = 9'(e); modulation = 10'(md);
      sample_clk_en = tk; key_on_pulse = kon;
   endtask

   task automatic idle();
      sample_clk_en = 1'b0;
      key_on_pulse  = 1'b0;
   endtask

   task automatic run_sample(input string tag, input int op, input int f, input int b,
                             input int m, input int w, input int e, input int md,
                             input bit kon, input int expv);
      drive(op, f, b, m, w, e, md, 1'b1, kon);
      model_update(op, f, b, m, 1'b1, kon);
      @(posedge clk); #1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check({tag, "/early"}, int'(out_valid), 0);
      @(posedge clk); #1;
      check({tag, "/valid"}, int'(out_valid), 1);
      check({tag, "/tag"}, int'(out_op_num), op);
      check({tag, "/out"}, int'(out), expv);
   endtask

   initial begin
      foreach (ph[i]) ph[i] = 0;
      rst = 1'b1;
      drive(3, 512, 1, 1, 0, 0, 0, 1'b1, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_out", int'(out), 0);
         check("rst_valid", int'(out_valid), 0);
      end
      rst = 1'b0;
      idle();
      check("rst_tag", int'(out_op_num), 0);

      run_sample("first", 5, 512, 1, 1, 0, 0, 0, 1'b0, ref_out(0, 0, 0, 0));

      // Reset while a sample is in flight: no strobe may emerge.
      drive(1, 512, 1, 1, 0, 0, 0, 1'b1, 1'b0);
      @(posedge clk); #1;
      idle();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      foreach (ph[i]) ph[i] = 0;
      repeat (4) begin
         @(posedge clk); #1;
         check("drop_valid", int'(out_valid), 0);
      end

      for (int k = 0; k < 256; k++) begin
         drive(3, 512, 1, 1, 0, 0, 0, 1'b1, 1'b0);
         model_update(3, 512, 1, 1, 1'b1, 1'b0);
         @(posedge clk); #1;
      end
      idle();
      repeat (5) @(posedge clk);
      #1;

      run_sample("adv_full",  3, 0, 0, 0, 0, 0, 0,    1'b0, 4084);
      run_sample("ws0_neg",   3, 0, 0, 0, 0, 0, 512,  1'b0, -4084);
      run_sample("ws1_mute",  3, 0, 0, 0, 1, 0, 512,  1'b0, 0);
      run_sample("ws2_abs",   3, 0, 0, 0, 2, 0, 512,  1'b0, 4084);
      run_sample("ws1_pos",   3, 0, 0, 0, 1, 0, 0,    1'b0, 4084);
      run_sample("ws3_mute",  3, 0, 0, 0, 3, 0, 0,    1'b0, 0);
      run_sample("ws3_pos",   3, 0, 0, 0, 3, 0, 1023, 1'b0, 4084);
      run_sample("ws0_idx512", 3, 0, 0, 0, 0, 0, 256, 1'b0, ref_out(262144, 256, 0, 0));
      run_sample("env32",     3, 0, 0, 0, 0, 32, 0,   1'b0, 2042);
      run_sample("silence0",  3, 0, 0, 0, 0, 511, 0,   1'b0, 0);
      run_sample("silence1",  3, 0, 0, 0, 0, 511, 300, 1'b0, 0);
      run_sample("silence2",  3, 0, 0, 0, 2, 511, 900, 1'b0, 0);

      run_sample("kon_a",    7, 1000, 7, 5, 0, 0, 0, 1'b0, ref_out(0, 0, 0, 0));
      run_sample("kon_b",    7, 625, 5, 3, 0, 0, 0, 1'b0, ref_out(640000, 0, 0, 0));
      run_sample("kon_tick", 7, 512, 1, 1, 0, 0, 0, 1'b1, ref_out(700000, 0, 0, 0));
      run_sample("kon_zero", 7, 0, 0, 0, 0, 0, 0, 1'b0, ref_out(0, 0, 0, 0));
      run_sample("kon_other", 3, 0, 0, 0, 0, 0, 0, 1'b0, 4084);

      run_sample("wrap_load", 0, 800, 7, 10, 0, 0, 0, 1'b0, ref_out(0, 0, 0, 0));
      run_sample("wrap_76",   0, 0, 0, 0, 0, 0, 100, 1'b0, ref_out(1024000, 100, 0, 0));
      run_sample("wrap_256",  0, 0, 0, 0, 0, 0, 280, 1'b0, 4084);

      // Back-to-back ticks for ops 0 and 17.
      drive(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(17, 512, 1, 1, 0, 0, 0, 1'b1, 1'b0);
      model_update(17, 512, 1, 1, 1'b1, 1'b0);
      @(posedge clk); #1;
      idle();
      @(posedge clk); #1;
      check("il/early", int'(out_valid), 0);
      @(posedge clk); #1;
      check("il0/valid", int'(out_valid), 1);
      check("il0/tag", int'(out_op_num), 0);
      check("il0/out", int'(out), ref_out(1024000, 0, 0, 0));
      @(posedge clk); #1;
      check("il17/valid", int'(out_valid), 1);
      check("il17/tag", int'(out_op_num), 17);
      check("il17/out", int'(out), ref_out(0, 0, 0, 0));
      @(posedge clk); #1;
      check("hold/valid", int'(out_valid), 0);
      check("hold/out", int'(out), ref_out(0, 0, 0, 0));
      check("hold/tag", int'(out_op_num), 17);

      run_sample("indep17", 17, 0, 0, 0, 0, 0, 0,   1'b0, ref_out(1024, 0, 0, 0));
      run_sample("indep0",  0,  0, 0, 0, 0, 0, 280, 1'b0, 4084);

      // Bare key-on (no tick) clears the phase without producing a strobe.
      drive(3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      model_update(3, 0, 0, 0, 1'b0, 1'b1);
      @(posedge clk); #1;
      idle();
      repeat (4) begin
         @(posedge clk); #1;
         check("kon_only/valid", int'(out_valid), 0);
      end
      run_sample("kon_only", 3, 0, 0, 0, 0, 0, 0, 1'b0, ref_out(0, 0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operator_waveform.md
# operator_waveform

Per-operator phase accumulation and waveform synthesis stage, directly downstream of `envelope_generator`. It advances a per-operator phase accumulator on each sample tick and applies phase modulation. A log-sine lookup adds the envelope attenuation, and an exponential lookup converts the result back to linear, giving a signed 13-bit operator sample. The operator output is consumed by the channel mixer and the feedback/modulation path.

## Interface
- `NUM_OPS`, default 18: operators per bank, one phase register each.
- `SILENCE`, default 511: envelope value treated as fully muted.
- `clk` in, 1: system clock.
- `rst` in, 1: synchronous, active-high reset.
- `sample_clk_en` in, 1: sample tick, qualifies the current `op_num`.
- `op_num` in, 5: operator currently presented.
- `fnum` in, 10: frequency number.
- `block` in, 3: octave.
- `mult` in, 4: frequency multiplier register.
- `ws` in, 2: waveform select.
- `env` in, 9: attenuation from `envelope_generator`, 0 = loudest.
- `modulation` in, 10: phase offset from the modulator or feedback path, two's-complement mod 1024.
- `key_on_pulse` in, 1: resets the phase of `op_num`.
- `out` out, 13 signed: operator sample.
- `out_op_num` out, 5: operator tag for `out`.
- `out_valid` out, 1: one-cycle strobe; `out` and `out_op_num` are valid while it is high.

## Operation
- **Multiplier table.** `mult` 0..15 maps to `mult2` = 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
- **Phase increment.** inc = ((fnum << block) * mult2) >> 1, truncated to 20 bits.
- **Phase register update, per operator `i`.** Each `phase[i]` is 20 bits, reset to 0. The cases are evaluated in priority order:
  1. `rst`: phase[i] <= 0.
  2. `key_on_pulse && op_num==i`: phase[i] <= 0. This wins over the advance in the same cycle.
  3. `sample_clk_en && op_num==i`: phase[i] <= phase[i] + inc, wrapping mod 2^20.
- **Pipeline input.** Stage 0 samples the pre-update phase.
- **Phase index.** idx = (phase[19:10] + modulation) mod 1024. Within the index:
  - idx[9] is the sign half.
  - idx[8] mirrors the quarter: lookup address = idx[8] ? ~idx[7:0] : idx[7:0].
- **Waveforms.**
  - ws0: full sine. Negative when idx[9] = 1.
  - ws1: half sine. Muted when idx[9] = 1. Always positive.
  - ws2: absolute sine. Always positive.
  - ws3: quarter pulse. Muted when idx[8] = 1. Always positive.
- **Log-sine ROM.** 256 x 12-bit, registered output: logsin[a] = round(-log2(sin((a+0.5)·π/512))·256).
- **Attenuation.** att = logsin + (env << 3), 13 bits unsigned with no overflow (max 2137+4088).
- **Exponential ROM.** 256 x 10-bit, registered output: exp[a] = round((2^(a/256) - 1)·1024).
- **Magnitude.** mag = ((exp[~att[7:0]] + 1024) << 1) >> att[12:8], 12 bits. mag = 0 when att[12:8] >= 12.
- **Output.** out = negative ? -mag : mag. Mute conditions force out = 0:
  - env >= SILENCE;
  - the ws1 or ws3 mute region.
- Non-tick cycles (`sample_clk_en` = 0) produce no `out_valid` and leave all phases unchanged.

## Timing
- **Reset values.** `out` = 0, `out_op_num` = 0, `out_valid` = 0, all phases 0, pipeline valid bits cleared. Reset mid-pipeline drops in-flight samples, and no `out_valid` fires for them.
- **Pipeline, 4 cycles.**
  - S0 registers idx, sign, mute, `env`, `op_num`, and the tick.
  - S1 performs the log-sine ROM read.
  - S2 registers att and performs the exp ROM read.
  - S3 applies shift, sign and mute and registers `out`.
- **Latency.** `out_valid` rises exactly 4 cycles after the `sample_clk_en` cycle, with `out_op_num` = that `op_num`.
- **Throughput.** Fully pipelined; back-to-back ticks for different operators each produce a strobe 4 cycles later.
- **Input alignment.** `env`, `modulation`, `ws`, `fnum`, `block` and `mult` are captured only in the tick cycle. The caller aligns `env` to the tick.
- **Key-on plus tick, same cycle.** The sample uses the old phase, and the phase is then 0, not advanced.
- **Hold between updates.** `out` holds its value between strobes.

## Test plan
- **Reset.** Assert `rst` 2 cycles with ticks present -> `out` = 0 and `out_valid` = 0 throughout. After release, the first tick yields a strobe exactly 4 cycles later.
- **Phase advance.** fnum=512, block=1, mult=1 (mult2=2) -> inc=1024. After 256 ticks on op 3, phase[3]=2^18 and idx=256. With ws0 and env=0, `out` is positive full scale, about +4084.
- **Sign and mute.** At idx=512+256, the same settings give ws0 ≈ -4084, ws1 = 0, ws2 ≈ +4084. At idx=256 with ws3, `out` = 0.
- **Envelope scaling.** env=32 (att += 256) halves |out|. env=511 gives 0 at every phase.
- **Key-on reset.** Phase at 700000, key_on_pulse together with a tick -> the strobe reflects phase 700000 and the next tick samples phase 0. Other operators' phases are unchanged.
- **Modulation wrap and independence.** phase index 1000 with modulation=100 -> idx=76. Interleave ticks for ops 0 and 17 on consecutive cycles -> two strobes in order, with correct tags and independent phases.
